// File: rtl/rom_loader_pkg.sv
// Shared types for the boot-time instruction-memory loader.
// Optional checksum support is enabled by defining ROM_LOADER_CSUM_EN.
package rom_loader_pkg;

  localparam int LDR_HDR_BYTES = 4;
  localparam int ROM_SIZE      = 4096;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_LEN,
    LDR_DATA,
    LDR_CSUM,
    LDR_DONE,
    LDR_ERR
  } ldr_state_t;

  // States in which the loader consumes stream bytes.
  function automatic logic ldr_active(input ldr_state_t s);
    return (s == LDR_LEN) || (s == LDR_DATA) || (s == LDR_CSUM);
  endfunction

endpackage

// File: rtl/rom_loader.sv
// Boot loader: takes a 4-byte big-endian length header plus image and writes it byte-wise
// from address 0. Define ROM_LOADER_CSUM_EN to require a trailing two's-complement checksum byte.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int MEM_BYTES = ROM_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_data_o,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] len_o
);

  ldr_state_t  state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] len_reg, len_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [7:0]  data_reg, data_next;
  logic [31:0] len_shift;
  logic        accept;
`ifdef ROM_LOADER_CSUM_EN
  logic [7:0]  sum_reg, sum_next;
  logic [7:0]  csum_total;
`endif

  assign byte_ready_o = ldr_active(state_reg);
  assign busy_o       = ldr_active(state_reg);
  assign accept       = byte_valid_i & byte_ready_o;
  assign len_shift    = {len_reg[23:0], byte_i};
  assign done_o       = (state_reg == LDR_DONE);
  assign err_o        = (state_reg == LDR_ERR);
  // A failed image keeps the core parked until a later load succeeds.
  assign cpu_hold_o   = ldr_active(state_reg) || (state_reg == LDR_ERR);
  assign mem_we_o     = we_reg;
  assign mem_addr_o   = addr_reg;
  assign mem_data_o   = data_reg;
  assign len_o        = len_reg;
`ifdef ROM_LOADER_CSUM_EN
  assign csum_total   = sum_reg + byte_i;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    data_next  = data_reg;
`ifdef ROM_LOADER_CSUM_EN
    sum_next   = sum_reg;
`endif
    case (state_reg)
      LDR_IDLE, LDR_DONE, LDR_ERR: begin
        if (start_i) begin
          state_next = LDR_LEN;
          cnt_next   = '0;
          len_next   = '0;
`ifdef ROM_LOADER_CSUM_EN
          sum_next   = '0;
`endif
        end
      end
      LDR_LEN: begin
        if (accept) begin
          len_next = len_shift;
          if (cnt_reg == 32'(LDR_HDR_BYTES - 1)) begin
            cnt_next = '0;
            if (len_shift > 32'(MEM_BYTES)) begin
              state_next = LDR_ERR;
            end else if (len_shift == '0) begin
`ifdef ROM_LOADER_CSUM_EN
              state_next = LDR_CSUM;
`else
              state_next = LDR_DONE;
`endif
            end else begin
              state_next = LDR_DATA;
            end
          end else begin
            cnt_next = cnt_reg + 32'd1;
          end
        end
      end
      LDR_DATA: begin
        if (accept) begin
          we_next   = 1'b1;
          addr_next = cnt_reg;
          data_next = byte_i;
          cnt_next  = cnt_reg + 32'd1;
`ifdef ROM_LOADER_CSUM_EN
          sum_next  = sum_reg + byte_i;
`endif
          if (cnt_reg == len_reg - 32'd1) begin
`ifdef ROM_LOADER_CSUM_EN
            state_next = LDR_CSUM;
`else
            state_next = LDR_DONE;
`endif
          end
        end
      end
`ifdef ROM_LOADER_CSUM_EN
      LDR_CSUM: begin
        // Checksum byte is consumed but never written to memory.
        if (accept) begin
          state_next = (csum_total == 8'h00) ? LDR_DONE : LDR_ERR;
        end
      end
`endif
      default: state_next = LDR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LDR_IDLE;
      cnt_reg   <= '0;
      len_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
`ifdef ROM_LOADER_CSUM_EN
      sum_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
`ifdef ROM_LOADER_CSUM_EN
      sum_reg   <= sum_next;
`endif
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed table of loads, reset-abort sequence and
// randomized loads checked against a stream-level reference model.
module tb_rom_loader;

  localparam int MEM = 4096;
`ifdef ROM_LOADER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_o;
  logic        cpu_hold_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] len_o;

  rom_loader #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .byte_i(byte_i),
    .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .cpu_hold_o(cpu_hold_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .len_o(len_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [39:0] wq[$];
  logic [7:0]  stream_q[$];

  always @(negedge clk) begin
    if (mem_we_o === 1'b1) wq.push_back({mem_addr_o, mem_data_o});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Offer one byte until accepted; data bytes must show up as a write one edge later.
  task automatic send_byte(input logic [7:0] b, input bit is_data, input int idx, input int gap);
    bit acc = 1'b0;
    byte_i = b;
    byte_valid_i = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = byte_ready_o;
      @(posedge clk); #1;
    end
    byte_valid_i = 1'b0;
    check("accept", 32'(acc), 32'd1);
    if (acc && is_data) begin
      @(negedge clk);
      check("wr_strobe", 32'(mem_we_o), 32'd1);
      check("wr_addr", mem_addr_o, 32'(idx));
      check("wr_data", 32'(mem_data_o), 32'(b));
      @(posedge clk); #1;
      // Rewind is impossible, so the extra half cycle acts as a one-cycle gap.
    end else if (gap == 1 || (gap == 2 && $urandom_range(1) == 1)) begin
      @(posedge clk); #1;
    end
  endtask

  // Build header + image (+ checksum byte when enabled) into stream_q.
  task automatic build(input int unsigned len, input logic [31:0] pat, input bit use_pat,
                       input bit rnd, input bit bad_csum);
    logic [7:0] b;
    logic [7:0] sum = 8'h00;
    stream_q.delete();
    for (int i = 3; i >= 0; i--) stream_q.push_back(8'((len >> (8 * i)) & 32'hFF));
    if (len <= MEM) begin
      for (int unsigned k = 0; k < len; k++) begin
        if (use_pat && k < 4) b = 8'((pat >> (8 * (3 - k))) & 32'hFF);
        else if (rnd) b = 8'($urandom_range(255));
        else b = 8'((k * 7 + 3) & 255);
        stream_q.push_back(b);
        sum = sum + b;
      end
      if (CSUM_ON) stream_q.push_back(8'(9'h100 - {1'b0, sum}) + 8'(bad_csum));
    end
  endtask

  task automatic run_load(input string tag, input bit exp_done, input bit exp_err,
                          input int gap, input int mid_start);
    int unsigned len;
    int unsigned nwr;
    len = {stream_q[0], stream_q[1], stream_q[2], stream_q[3]};
    nwr = (len > MEM) ? 0 : len;
    wq.delete();
    pulse_start();
    check({tag, "_busy_on"}, 32'(busy_o), 32'd1);
    check({tag, "_hold_on"}, 32'(cpu_hold_o), 32'd1);
    check({tag, "_flags_clr"}, {30'd0, done_o, err_o}, 32'd0);
    for (int i = 0; i < 4; i++) send_byte(stream_q[i], 1'b0, 0, gap);
    for (int k = 0; k < int'(nwr); k++) begin
      if (k == mid_start) pulse_start();
      send_byte(stream_q[4 + k], 1'b1, k, gap);
    end
    if (CSUM_ON && len <= MEM) send_byte(stream_q[4 + nwr], 1'b0, 0, gap);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_done"}, 32'(done_o), 32'(exp_done));
    check({tag, "_err"}, 32'(err_o), 32'(exp_err));
    check({tag, "_hold"}, 32'(cpu_hold_o), 32'(exp_err));
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    check({tag, "_len"}, len_o, len);
    check({tag, "_nwrites"}, wq.size(), nwr);
    for (int k = 0; k < wq.size() && k < int'(nwr); k++)
      check({tag, "_write"}, {wq[k][39:8], 24'd0} | 32'(wq[k][7:0]) ,
            {32'(k), 24'd0} | 32'(stream_q[4 + k]));
    $display("load %s: len=%0d writes=%0d done=%0b err=%0b", tag, len, wq.size(), done_o, err_o);
  endtask

  typedef struct {
    int unsigned len;
    logic [31:0] pat;
    bit          use_pat;
    bit          bad_csum;
    int          gap;
    int          mid_start;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{4,    32'hDEADBEEF, 1'b1, 1'b0, 0, -1, 1'b1, 1'b0};
    vecs[1] = '{4097, 32'h0,        1'b0, 1'b0, 0, -1, 1'b0, 1'b1};
    vecs[2] = '{4,    32'h01020304, 1'b1, 1'b0, 0, -1, 1'b1, 1'b0};
    vecs[3] = '{4,    32'h01020304, 1'b1, 1'b1, 0, -1, !CSUM_ON, CSUM_ON};
    vecs[4] = '{8,    32'h0,        1'b0, 1'b0, 1, 3,  1'b1, 1'b0};
    vecs[5] = '{0,    32'h0,        1'b0, 1'b0, 0, -1, 1'b1, 1'b0};
    vecs[6] = '{4096, 32'h0,        1'b0, 1'b0, 0, -1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(byte_ready_o), 32'd0);
    check("rst_hold", 32'(cpu_hold_o), 32'd0);
    check("rst_flags", {29'd0, busy_o, done_o, err_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_we", 32'(mem_we_o), 32'd0);
    check("idle_addr", mem_addr_o, 32'd0);
    check("idle_len", len_o, 32'd0);
    check("idle_ready", 32'(byte_ready_o), 32'd0);

    for (int i = 0; i < 7; i++) begin
      build(vecs[i].len, vecs[i].pat, vecs[i].use_pat, 1'b0, vecs[i].bad_csum);
      run_load($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err,
               vecs[i].gap, vecs[i].mid_start);
    end

    // Reset after two of eight data bytes aborts the load immediately.
    build(8, 32'h0, 1'b0, 1'b1, 1'b0);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(stream_q[i], 1'b0, 0, 0);
    for (int k = 0; k < 2; k++) send_byte(stream_q[4 + k], 1'b1, k, 0);
    rst = 1'b1;
    #1;
    check("abort_we", 32'(mem_we_o), 32'd0);
    check("abort_addr", mem_addr_o, 32'd0);
    check("abort_data", 32'(mem_data_o), 32'd0);
    check("abort_flags", {28'd0, busy_o, done_o, err_o, cpu_hold_o}, 32'd0);
    check("abort_len", len_o, 32'd0);
    check("abort_ready", 32'(byte_ready_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_load("after_rst", 1'b1, 1'b0, 0, -1);

    // Randomized loads against the stream-level model.
    for (int r = 0; r < 20; r++) begin
      int unsigned len;
      bit bad;
      bit e_err;
      len = ($urandom_range(9) == 0) ? 32'd4097 + $urandom_range(100000) : $urandom_range(40);
      bad = ($urandom_range(3) == 0);
      build(len, 32'h0, 1'b0, 1'b1, bad);
      e_err = (len > MEM) || (CSUM_ON && bad);
      run_load($sformatf("rnd%0d", r), !e_err, e_err, 2, int'($urandom_range(45)) - 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
